// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between the processing elements and the shared
// add/subtract arbiter. The arbiter sits on the slave side.
interface addsub_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*WIDTH-1:0] req_a_i;
    logic [NREQ*WIDTH-1:0] req_b_i;
    logic [NREQ-1:0]       req_sub_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [IDW-1:0]        rsp_id_o;
    logic [WIDTH-1:0]      rsp_result_o;
    logic                  rsp_cout_o;
    logic                  rsp_overflow_o;
    logic                  rsp_zero_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_sub_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
               rsp_cout_o, rsp_overflow_o, rsp_zero_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_sub_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o,
               rsp_cout_o, rsp_overflow_o, rsp_zero_o
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational adder/subtractor between
// NREQ requesters, with a single registered valid/ready response slot.

module adder_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             zero_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;

    // Subtraction as a + ~b + 1, so the carry out reads as "no borrow" (a >= b).
    always_comb begin
        b_eff      = sub_i ? ~b_i : b_i;
        sum        = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
        result_o   = sum[WIDTH-1:0];
        cout_o     = sum[WIDTH];
        overflow_o = ((a_i[WIDTH-1] ^ b_i[WIDTH-1]) == sub_i) &&
                     (sum[WIDTH-1] != a_i[WIDTH-1]);
        zero_o     = (sum[WIDTH-1:0] == '0);
    end
endmodule

module addsub_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic           clk_i,
    input logic           rst_ni,
    addsub_arbiter_if.slave bus
);
    logic [IDW-1:0]   rr_q, rr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             can_accept;
    logic             fire;
    logic [IDW:0]     scan;
    logic [IDW-1:0]   scan_idx;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             sub_sel;
    logic [WIDTH-1:0] au_result;
    logic             au_cout, au_overflow, au_zero;

    // Round-robin search starting at rr_q; the first valid requester found wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        scan      = '0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_q} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            scan_idx = scan[IDW-1:0];
            if (!any_valid && bus.req_valid_i[scan_idx]) begin
                any_valid = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    // Operand mux for the granted requester; constant slices keep widths exact.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                a_sel   = bus.req_a_i[k*WIDTH +: WIDTH];
                b_sel   = bus.req_b_i[k*WIDTH +: WIDTH];
                sub_sel = bus.req_sub_i[k];
            end
        end
    end

    adder_subtractor #(.WIDTH(WIDTH)) u_addsub (
        .a_i        (a_sel),
        .b_i        (b_sel),
        .sub_i      (sub_sel),
        .result_o   (au_result),
        .cout_o     (au_cout),
        .overflow_o (au_overflow),
        .zero_o     (au_zero)
    );

    // Accept while the slot is empty or draining this cycle; nothing is
    // accepted while reset is held.
    always_comb begin
        can_accept      = rst_ni && (!rsp_valid_q || bus.rsp_ready_i);
        fire            = any_valid && can_accept;
        bus.req_ready_o = '0;
        if (any_valid) begin
            bus.req_ready_o[grant] = can_accept;
        end
    end

    // Next-state for the response slot and the round-robin pointer.
    always_comb begin
        rr_d           = rr_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_cout_d     = rsp_cout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;
        if (fire) begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = grant;
            rsp_result_d   = au_result;
            rsp_cout_d     = au_cout;
            rsp_overflow_d = au_overflow;
            rsp_zero_d     = au_zero;
            rr_d           = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q           <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_cout_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_cout_q     <= rsp_cout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
        end
    end

    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_id_o       = rsp_id_q;
    assign bus.rsp_result_o   = rsp_result_q;
    assign bus.rsp_cout_o     = rsp_cout_q;
    assign bus.rsp_overflow_o = rsp_overflow_q;
    assign bus.rsp_zero_o     = rsp_zero_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and randomized bench for addsub_arbiter with a cycle-level
// reference model built from plain integer arithmetic.
module tb_addsub_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic clk_i = 1'b0;
    logic rst_ni;

    addsub_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [NREQ-1:0]  vld;
    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];
    logic             op_sub [NREQ];
    logic             rsp_rdy;

    assign bus.req_valid_i = vld;
    assign bus.rsp_ready_i = rsp_rdy;
    for (genvar k = 0; k < NREQ; k++) begin : g_pack
        assign bus.req_a_i[k*WIDTH +: WIDTH] = op_a[k];
        assign bus.req_b_i[k*WIDTH +: WIDTH] = op_b[k];
        assign bus.req_sub_i[k]              = op_sub[k];
    end

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_rr, m_id, m_res;
    bit m_valid, m_cout, m_ovf, m_zero;
    bit hold_valid;
    int fired_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_valid = 0; m_id = 0; m_res = 0;
        m_cout = 0; m_ovf = 0; m_zero = 0;
    endtask

    // Arithmetic reference from integer values rather than bit manipulation.
    task automatic ref_op(input int a, input int b, input bit sub,
                          output int res, output bit cout, output bit ovf);
        int sa, sb, s, full;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        if (!sub) begin
            full = a + b;
            res  = full % 256;
            cout = (full >= 256);
            s    = sa + sb;
        end else begin
            full = a - b;
            res  = (full + 256) % 256;
            cout = (a >= b);
            s    = sa - sb;
        end
        ovf = (s > 127) || (s < -128);
    endtask

    task automatic check_rsp(input string tag);
        chk({tag, ".valid"}, bus.rsp_valid_o, m_valid);
        chk({tag, ".id"}, bus.rsp_id_o, m_id);
        chk({tag, ".result"}, bus.rsp_result_o, m_res);
        chk({tag, ".cout"}, bus.rsp_cout_o, m_cout);
        chk({tag, ".ovf"}, bus.rsp_overflow_o, m_ovf);
        chk({tag, ".zero"}, bus.rsp_zero_o, m_zero);
    endtask

    // One clock: check the combinational grant, advance the model, check outputs.
    task automatic cycle(input string tag);
        int g;
        bit any, can;
        logic [NREQ-1:0] exp_rdy;
        int res;
        bit c, o;
        #1;
        any = 0;
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_rr + i) % NREQ;
            if (!any && vld[k]) begin
                any = 1;
                g = k;
            end
        end
        can = (rst_ni === 1'b1) && (!m_valid || rsp_rdy);
        exp_rdy = '0;
        if (any && can) exp_rdy[g] = 1'b1;
        chk({tag, ".req_ready"}, bus.req_ready_o, exp_rdy);
        fired_id = -1;
        if (any && can) begin
            ref_op(op_a[g], op_b[g], op_sub[g], res, c, o);
            m_valid = 1; m_id = g; m_res = res; m_cout = c; m_ovf = o;
            m_zero = (res == 0);
            m_rr = (g + 1) % NREQ;
            fired_id = g;
        end else if (m_valid && rsp_rdy) begin
            m_valid = 0;
        end
        @(posedge clk_i);
        #1;
        if (fired_id >= 0 && !hold_valid) vld[fired_id] = 1'b0;
        check_rsp(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        rsp_rdy = 1'b1;
        hold_valid = 0;
        vld = '1;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = 8'(10 * k);
            op_b[k] = 8'(k);
            op_sub[k] = 1'b1;
        end
        model_reset();

        // Reset with all requests pending
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.req_ready", bus.req_ready_o, 0);
        chk("rst.valid", bus.rsp_valid_o, 0);
        chk("rst.id", bus.rsp_id_o, 0);
        chk("rst.result", bus.rsp_result_o, 0);
        chk("rst.flags", {bus.rsp_cout_o, bus.rsp_overflow_o, bus.rsp_zero_o}, 0);
        rst_ni = 1'b1;
        cycle("first");
        chk("first.id_const", bus.rsp_id_o, 0);
        vld = '0;

        // Single request from requester 2
        op_a[2] = 8'd200; op_b[2] = 8'd100; op_sub[2] = 1'b0;
        vld[2] = 1'b1;
        cycle("single");
        chk("single.id_const", bus.rsp_id_o, 2);
        chk("single.result_const", bus.rsp_result_o, 44);
        chk("single.flags_const", {bus.rsp_cout_o, bus.rsp_overflow_o, bus.rsp_zero_o}, 3'b100);
        cycle("single_drain");
        chk("single_drain.valid_const", bus.rsp_valid_o, 0);

        // Reset pulse between edges so the pointer restarts at 0
        #2 rst_ni = 1'b0;
        #1;
        chk("pulse.valid", bus.rsp_valid_o, 0);
        model_reset();
        #1 rst_ni = 1'b1;

        // Round robin with all requesters continuously valid
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = 8'(10 * k); op_b[k] = 8'(k); op_sub[k] = 1'b1;
        end
        vld = '1;
        hold_valid = 1;
        for (int n = 0; n < 6; n++) begin
            cycle("rr");
            chk("rr.id_seq", bus.rsp_id_o, n % 4);
            chk("rr.result_seq", bus.rsp_result_o, 9 * (n % 4));
            chk("rr.zero_seq", bus.rsp_zero_o, (n % 4) == 0);
            chk("rr.valid_seq", bus.rsp_valid_o, 1);
        end
        hold_valid = 0;
        vld = '0;
        cycle("rr_drain");

        // Backpressure with 127+1 held in the response register
        op_a[1] = 8'd127; op_b[1] = 8'd1; op_sub[1] = 1'b0;
        vld[1] = 1'b1;
        cycle("bp_load");
        chk("bp_load.result_const", bus.rsp_result_o, 128);
        chk("bp_load.ovf_const", bus.rsp_overflow_o, 1);
        rsp_rdy = 1'b0;
        op_a[2] = 8'd5; op_b[2] = 8'd3; op_sub[2] = 1'b0;
        vld[2] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle("bp_hold");
            chk("bp_hold.req_ready_const", bus.req_ready_o, 0);
            chk("bp_hold.id_const", bus.rsp_id_o, 1);
            chk("bp_hold.result_const", bus.rsp_result_o, 128);
        end
        rsp_rdy = 1'b1;
        #1;
        chk("bp_release.req_ready_const", bus.req_ready_o, 4'b0100);
        cycle("bp_release");
        chk("bp_release.id_const", bus.rsp_id_o, 2);
        chk("bp_release.result_const", bus.rsp_result_o, 8);

        // Signed subtraction flags
        op_a[0] = 8'h80; op_b[0] = 8'h01; op_sub[0] = 1'b1;
        vld[0] = 1'b1;
        cycle("sub_ovf");
        chk("sub_ovf.result_const", bus.rsp_result_o, 8'h7f);
        chk("sub_ovf.flags_const", {bus.rsp_cout_o, bus.rsp_overflow_o}, 2'b11);
        op_a[0] = 8'd50; op_b[0] = 8'd100; op_sub[0] = 1'b1;
        vld[0] = 1'b1;
        cycle("sub_borrow");
        chk("sub_borrow.result_const", bus.rsp_result_o, 206);
        chk("sub_borrow.flags_const", {bus.rsp_cout_o, bus.rsp_overflow_o}, 2'b00);

        // Pointer wrap from 3 to 0, then asynchronous reset mid-stream
        op_a[3] = 8'd1; op_b[3] = 8'd2; op_sub[3] = 1'b0;
        vld[3] = 1'b1;
        cycle("wrap3");
        chk("wrap3.id_const", bus.rsp_id_o, 3);
        op_a[0] = 8'd7; op_b[0] = 8'd7; op_sub[0] = 1'b1;
        op_a[3] = 8'd9; op_b[3] = 8'd9; op_sub[3] = 1'b0;
        vld = 4'b1001;
        cycle("wrap0");
        chk("wrap0.id_const", bus.rsp_id_o, 0);
        chk("wrap0.zero_const", bus.rsp_zero_o, 1);
        rsp_rdy = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        chk("async_rst.valid", bus.rsp_valid_o, 0);
        chk("async_rst.result", bus.rsp_result_o, 0);
        chk("async_rst.id", bus.rsp_id_o, 0);
        model_reset();
        vld = '0;
        #1 rst_ni = 1'b1;
        rsp_rdy = 1'b1;
        cycle("post_rst");

        // Randomized traffic honouring the requester protocol
        for (int n = 0; n < 400; n++) begin
            rsp_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!vld[k] && ($urandom_range(0, 1) == 1)) begin
                    vld[k] = 1'b1;
                    op_a[k] = 8'($urandom);
                    op_b[k] = 8'($urandom);
                    op_sub[k] = 1'($urandom_range(0, 1));
                end
            end
            cycle("rand");
        end
        vld = '0;
        rsp_rdy = 1'b1;
        cycle("final_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
